// File: rtl/add_serial_pkg.sv
// Shared types and constants for the serial-adder arbiter and its datapath core.
package add_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_add_core.sv
// Bit-serial ripple adder: operand shift registers, carry flop, sum shifter and bit counter.
module serial_add_core
  import add_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q,
  output logic             last
);

  // One extra counter bit so the count can never wrap before the last shift.
  localparam int CNTW = clog2(WIDTH) + 1;

  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [CNTW-1:0]  count_q;
  logic             sum_bit;

  assign sum_bit = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign last    = (count_q == CNTW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
    end else if (load) begin
      a_sh_q  <= a;
      b_sh_q  <= b;
      carry_q <= 1'b0;
      count_q <= '0;
    end else if (shift) begin
      a_sh_q  <= a_sh_q >> 1;
      b_sh_q  <= b_sh_q >> 1;
      carry_q <= (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
      sum_q   <= {sum_bit, sum_q[WIDTH-1:1]};
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/add_serial_arbiter.sv
// Round-robin arbiter that shares one serial_add_core among NREQ requesters.
//   state | meaning
//   IDLE  | waiting for any request; picks winner from ptr upward
//   LOAD  | grant pulse, operands of owner latched into the core
//   ADD   | WIDTH serial add cycles, LSB first
//   DONE  | done pulse with result/carry_out, pointer advances past owner
module add_serial_arbiter
  import add_serial_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDXW  = (NREQ > 1) ? clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      result,
  output logic                  carry_out,
  output logic [IDXW-1:0]       owner
);

  state_t           state_q, state_d;
  logic [IDXW-1:0]  owner_q, owner_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic [IDXW-1:0]  winner;
  logic             found;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             load, shift, last, core_carry;
  logic [WIDTH-1:0] core_sum, a_sel, b_sel;

  assign a_sel = a_in[owner_q*WIDTH +: WIDTH];
  assign b_sel = b_in[owner_q*WIDTH +: WIDTH];

  serial_add_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift   (shift),
    .a       (a_sel),
    .b       (b_sel),
    .sum_q   (core_sum),
    .carry_q (core_carry),
    .last    (last)
  );

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr_q) + k) % NREQ]) begin
        winner = IDXW'((int'(ptr_q) + k) % NREQ);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    load        = 1'b0;
    shift       = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = winner;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load    = 1'b1;
        state_d = ADD;
      end
      ADD: begin
        shift = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        result_d    = core_sum;
        carry_out_d = core_carry;
        ptr_d       = IDXW'((int'(owner_q) + 1) % NREQ);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
    end
  end

  always_comb begin
    gnt  = '0;
    done = '0;
    if (state_q == LOAD) gnt[owner_q] = 1'b1;
    if (state_q == DONE) done[owner_q] = 1'b1;
  end

  // The core sum is already final in DONE, so bypass the holding register
  // to present the result alongside the done pulse.
  assign result    = (state_q == DONE) ? core_sum : result_q;
  assign carry_out = (state_q == DONE) ? core_carry : carry_out_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_add_serial_arbiter.sv
// Directed bench for add_serial_arbiter: latency, overflow, contention, fairness and mid-op events.
module tb_add_serial_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDXW  = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      result;
  logic                  carry_out;
  logic [IDXW-1:0]       owner;

  int vecs;
  int errs;
  int cyc;
  int gcyc;
  int gap;
  int t0;
  logic [WIDTH:0] ref_sum;
  logic [WIDTH-1:0] ca [NREQ];
  logic [WIDTH-1:0] cb [NREQ];

  add_serial_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs = vecs + 1;
    assert (obs === exp) else begin
      errs = errs + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Waits (bounded) for the grant, then checks the done cycle WIDTH+1 later.
  task automatic do_txn(input string tag, input int idx, input logic [WIDTH-1:0] es, input logic ec);
    int k;
    k = 0;
    while (gnt == '0 && k < 30) begin
      tick();
      k = k + 1;
    end
    chk({tag, "_gnt"}, 32'(gnt), 32'(1 << idx));
    chk({tag, "_owner"}, 32'(owner), 32'(idx));
    gap  = cyc - gcyc;
    gcyc = cyc;
    repeat (WIDTH + 1) tick();
    chk({tag, "_done"}, 32'(done), 32'(1 << idx));
    chk({tag, "_result"}, 32'(result), 32'(es));
    chk({tag, "_carry"}, 32'(carry_out), 32'(ec));
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    cyc  = 0;
    gcyc = 0;
    gap  = 0;
    rst  = 1'b0;
    req  = '0;
    a_in = '0;
    b_in = '0;

    // Reset state
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_carry", 32'(carry_out), 0);
    chk("rst_owner", 32'(owner), 0);
    rst = 1'b1;
    tick();

    // Single add: 0x3C + 0x05 = 0x41, gnt at cycle 1, done at cycle 10
    a_in[0*WIDTH +: WIDTH] = 8'h3C;
    b_in[0*WIDTH +: WIDTH] = 8'h05;
    req = 4'b0001;
    t0 = cyc;
    tick();
    chk("single_gnt_c1", 32'(gnt), 32'h1);
    chk("single_busy_c1", 32'(busy), 1);
    repeat (8) tick();
    chk("single_nodone_c9", 32'(done), 0);
    tick();
    chk("single_done_lat", 32'(cyc - t0), 10);
    chk("single_done", 32'(done), 32'h1);
    chk("single_result", 32'(result), 32'h41);
    chk("single_carry", 32'(carry_out), 0);
    req = '0;
    tick();
    chk("single_busy_c11", 32'(busy), 0);
    chk("single_done_c11", 32'(done), 0);
    chk("single_result_held", 32'(result), 32'h41);
    tick();

    // Overflow on requester 2
    a_in[2*WIDTH +: WIDTH] = 8'hFF;
    b_in[2*WIDTH +: WIDTH] = 8'h01;
    req = 4'b0100;
    do_txn("ovf1", 2, 8'h00, 1'b1);
    a_in[2*WIDTH +: WIDTH] = 8'h80;
    b_in[2*WIDTH +: WIDTH] = 8'h80;
    do_txn("ovf2", 2, 8'h00, 1'b1);
    chk("ovf_spacing", 32'(gap), 11);
    req = '0;
    tick();
    tick();

    // Full contention from a fresh pointer
    do_reset();
    ca[0] = 8'h11; cb[0] = 8'h22;
    ca[1] = 8'h7F; cb[1] = 8'h81;
    ca[2] = 8'hC8; cb[2] = 8'h40;
    ca[3] = 8'hAA; cb[3] = 8'h55;
    for (int i = 0; i < NREQ; i++) begin
      a_in[i*WIDTH +: WIDTH] = ca[i];
      b_in[i*WIDTH +: WIDTH] = cb[i];
    end
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      ref_sum = {1'b0, ca[n % NREQ]} + {1'b0, cb[n % NREQ]};
      do_txn("cont", n % NREQ, ref_sum[WIDTH-1:0], ref_sum[WIDTH]);
      if (n > 0) chk("cont_spacing", 32'(gap), 11);
    end

    // Fairness: requesters 0 and 2 held
    do_reset();
    req = 4'b0101;
    for (int n = 0; n < 4; n++) begin
      ref_sum = {1'b0, ca[(n % 2) * 2]} + {1'b0, cb[(n % 2) * 2]};
      do_txn("fair", (n % 2) * 2, ref_sum[WIDTH-1:0], ref_sum[WIDTH]);
    end

    // Requester 1 drops req and changes its operand after LOAD
    do_reset();
    a_in[1*WIDTH +: WIDTH] = 8'h12;
    b_in[1*WIDTH +: WIDTH] = 8'h34;
    req = 4'b0010;
    tick();
    chk("mid_gnt", 32'(gnt), 32'h2);
    tick();
    req = '0;
    a_in[1*WIDTH +: WIDTH] = 8'hFF;
    repeat (8) tick();
    chk("mid_done", 32'(done), 32'h2);
    chk("mid_result", 32'(result), 32'h46);
    chk("mid_carry", 32'(carry_out), 0);
    tick();

    // Reset during ADD aborts the transaction
    a_in[0*WIDTH +: WIDTH] = 8'hF0;
    b_in[0*WIDTH +: WIDTH] = 8'h20;
    req = 4'b0001;
    tick();
    chk("abort_gnt", 32'(gnt), 32'h1);
    repeat (4) tick();
    req = '0;
    rst = 1'b0;
    tick();
    chk("abort_gnt0", 32'(gnt), 0);
    chk("abort_done0", 32'(done), 0);
    chk("abort_busy0", 32'(busy), 0);
    chk("abort_result0", 32'(result), 0);
    chk("abort_carry0", 32'(carry_out), 0);
    chk("abort_owner0", 32'(owner), 0);
    rst = 1'b1;
    begin
      logic [NREQ-1:0] seen;
      seen = '0;
      repeat (10) begin
        tick();
        seen = seen | done;
      end
      chk("abort_no_done", 32'(seen), 0);
    end

    // Requester 3 after the aborted transaction
    a_in[3*WIDTH +: WIDTH] = 8'h9A;
    b_in[3*WIDTH +: WIDTH] = 8'h77;
    req = 4'b1000;
    do_txn("post_rst", 3, 8'h11, 1'b1);
    req = '0;
    tick();
    chk("post_rst_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/add_serial_arbiter.md
Name: add_serial_arbiter

Overview:
Shares one bit-serial ripple adder among NREQ requesters using round-robin arbitration. Each transaction runs as follows: the winner's operands are latched, WIDTH serial add cycles run LSB-first, and the winner then receives a done pulse with the sum and carry-out. The block sits between the operand-producing clients and the serial add datapath, and owns all sequencing of that datapath: load, shift, count and completion.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, operand/result width in bits (2..32)
IDXW, 2, requester index width, equal to clog2(NREQ)

Ports:
clk  input  1  single clock; all state updates on posedge
rst  input  1  synchronous, active-low reset; sampled on posedge clk
req  input  NREQ  per-requester request level
a_in  input  NREQ*WIDTH  packed A operands; requester i uses bits [i*WIDTH +: WIDTH]
b_in  input  NREQ*WIDTH  packed B operands, same packing as a_in
gnt  output  NREQ  one-hot; high only during the LOAD cycle of the granted requester
busy  output  1  high in every state except IDLE
done  output  NREQ  one-hot, one-cycle completion pulse to the owning requester
result  output  WIDTH  sum of the last completed transaction; held until the next completion
carry_out  output  1  final carry of the last completed transaction; held like result
owner  output  IDXW  index of the current or last granted requester

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, rr pointer=0.
  - gnt, done, busy, result, carry_out, owner, shift registers and count all 0.
  - Reset mid-transaction aborts the transaction; no done is issued.
- FSM states: IDLE, LOAD, ADD, DONE.
- IDLE:
  - If req!=0, select the first set bit searching from ptr upward, wrapping modulo NREQ.
  - Register the winner into owner; next state LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - gnt[owner]=1 (decoded from state and owner).
  - Latch a_in/b_in slices of owner into a_sh/b_sh; carry=0, count=0.
  - Next state ADD.
- ADD, each cycle:
  - sum = a_sh[0]^b_sh[0]^carry.
  - carry <= majority(a_sh[0], b_sh[0], carry).
  - a_sh, b_sh shift right by 1; sum_sh <= {sum, sum_sh[WIDTH-1:1]}; count++.
  - When count==WIDTH-1, this is the last shift; next state DONE.
  - count width is clog2(WIDTH)+1, so it never wraps before terminating.
- DONE:
  - result <= sum_sh and carry_out <= carry, both registered in this cycle.
  - done[owner]=1 for exactly this cycle; result and carry_out are visible in the same cycle as done.
  - ptr <= (owner+1) mod NREQ; next state IDLE.
- Latency: req high in cycle 0 with the block idle gives:
  - gnt in cycle 1.
  - done in cycle WIDTH+2 (cycle 10 for WIDTH=8).
  - Minimum period between grants is WIDTH+3 cycles.
- Handshake:
  - Operands are sampled only in the LOAD cycle; a_in/b_in may change afterwards.
  - The requester must drop req in the cycle after done if it has no further work. Otherwise it re-enters arbitration at lowest priority.
- Boundary cases:
  - req deasserted by the owner during LOAD/ADD: the transaction still completes and done still pulses.
  - New requests arriving during LOAD/ADD/DONE are ignored until IDLE.
  - All requesters simultaneously: serviced in pointer order.
  - NREQ=1 degenerates to a fixed grant.
  - Overflow is reported only via carry_out; result wraps modulo 2^WIDTH.
- Out-of-range state encodings return to IDLE.

Decomposition:
- Shared package add_serial_pkg holds:
  - state localparams IDLE=0, LOAD=1, ADD=2, DONE=3 (2-bit);
  - default WIDTH and NREQ constants;
  - a clog2 function.
- One sub-module: serial_add_core.
  - Ports: clk, rst, load, shift, a, b, sum_q, carry_q, last.
  - Contains the shift registers, carry register and bit counter.
- add_serial_arbiter keeps the FSM, the round-robin pointer and the output decode.

Test Plan:
- Single add: req=4'b0001, a0=0x3C, b0=0x05, WIDTH=8.
  - Expect gnt=0001 at cycle 1; done=0001 at cycle 10.
  - Expect result=0x41, carry_out=0, busy low at cycle 11.
- Overflow: req[2] only, a2=0xFF, b2=0x01.
  - Expect done[2] with result=0x00, carry_out=1.
  - Then a2=0x80, b2=0x80: expect result=0x00, carry_out=1.
- Full contention: req=4'b1111 held, distinct operands.
  - Expect grants in order 0,1,2,3,0, spaced 11 cycles apart.
  - Each done carries its own requester's correct sum.
- Fairness: req[0] and req[2] held continuously.
  - Expect grants alternating 0,2,0,2; req[1] and req[3] never granted.
- Mid-operation events:
  - req[1] dropped and a1 changed after LOAD: done[1] still pulses with the sum of the operands latched at LOAD.
  - rst low during ADD cycle 4: all outputs 0 next cycle, no done.
  - Then req=4'b1000: gnt[3] and a correct sum, with the pointer restarted from 0.
